// File: rtl/spi_reg_bridge.sv
// SPI-slave to register-bus bridge: byte 0 is a command (bit7 = read) with a start
// address, later bytes are written or read back with auto-incrementing addresses.
module spi_reg_bridge #(
    parameter int          ADDR_W     = 7,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter logic [7:0]  ERR_BYTE   = 8'hEE,
    parameter int          RD_TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    input  logic              i_spi_busy,
    input  logic              i_tx_ready,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    output logic [ADDR_W-1:0] o_reg_addr,
    output logic [7:0]        o_reg_wdata,
    output logic              o_reg_wr,
    output logic              o_reg_rd,
    input  logic [7:0]        i_reg_rdata,
    input  logic              i_reg_rvalid,
    output logic              o_err
);

    localparam int                TCNT_W    = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(RD_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        RD_REQ,
        RD_WAIT,
        RD_LOAD
    } state_t;

    state_t              state;
    logic                busy_p1;
    logic                busy_rise;
    logic                busy_fall;
    logic                sync_done;
    logic                echo_pend;
    logic [7:0]          echo_byte;
    logic                ld_done;
    logic [ADDR_W-1:0]   addr;
    logic [TCNT_W-1:0]   tcnt;
    logic [7:0]          cap;

    assign busy_rise = i_spi_busy & ~busy_p1;
    assign busy_fall = ~i_spi_busy & busy_p1;

    // busy_p1 resets high so a chip-select still asserted at reset release is not
    // mistaken for the start of a new frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            busy_p1     <= 1'b1;
            sync_done   <= 1'b0;
            echo_pend   <= 1'b0;
            echo_byte   <= 8'h00;
            ld_done     <= 1'b0;
            addr        <= '0;
            tcnt        <= '0;
            cap         <= 8'h00;
            o_tx_data   <= 8'h00;
            o_tx_valid  <= 1'b0;
            o_reg_addr  <= '0;
            o_reg_wdata <= 8'h00;
            o_reg_wr    <= 1'b0;
            o_reg_rd    <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            busy_p1    <= i_spi_busy;
            o_tx_valid <= 1'b0;
            o_reg_wr   <= 1'b0;
            o_reg_rd   <= 1'b0;
            o_err      <= 1'b0;

            // Writes are serviced ahead of the frame-end check so a byte arriving
            // together with chip-select release is still committed.
            if (state == WRITE) begin
                if (i_rx_valid) begin
                    o_reg_wr    <= 1'b1;
                    o_reg_wdata <= i_rx_data;
                    o_reg_addr  <= addr;
                    addr        <= addr + ADDR_ONE;
                    if (i_tx_ready) begin
                        o_tx_valid <= 1'b1;
                        o_tx_data  <= i_rx_data;
                        echo_pend  <= 1'b0;
                    end else begin
                        echo_pend  <= 1'b1;
                        echo_byte  <= i_rx_data;
                    end
                end else if (echo_pend && i_tx_ready) begin
                    o_tx_valid <= 1'b1;
                    o_tx_data  <= echo_byte;
                    echo_pend  <= 1'b0;
                end
            end

            if (busy_fall) begin
                state     <= IDLE;
                echo_pend <= 1'b0;
                ld_done   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!sync_done && i_tx_ready) begin
                            o_tx_valid <= 1'b1;
                            o_tx_data  <= SYNC_BYTE;
                            sync_done  <= 1'b1;
                        end
                        // Re-arm the sync load for the gap after this frame.
                        if (busy_rise) begin
                            state     <= CMD;
                            sync_done <= 1'b0;
                        end
                    end
                    CMD: begin
                        if (i_rx_valid) begin
                            addr  <= i_rx_data[ADDR_W-1:0];
                            state <= i_rx_data[7] ? RD_REQ : WRITE;
                        end
                    end
                    WRITE: begin
                    end
                    RD_REQ: begin
                        o_reg_rd   <= 1'b1;
                        o_reg_addr <= addr;
                        tcnt       <= '0;
                        state      <= RD_WAIT;
                    end
                    RD_WAIT: begin
                        if (i_reg_rvalid) begin
                            cap   <= i_reg_rdata;
                            state <= RD_LOAD;
                        end else if (tcnt == TCNT_LAST) begin
                            cap   <= ERR_BYTE;
                            o_err <= 1'b1;
                            state <= RD_LOAD;
                        end else begin
                            tcnt <= tcnt + TCNT_W'(1);
                        end
                    end
                    RD_LOAD: begin
                        // The master byte that clocks out this data is a dummy;
                        // its arrival triggers the prefetch of the next address.
                        if (!ld_done) begin
                            if (i_tx_ready) begin
                                o_tx_valid <= 1'b1;
                                o_tx_data  <= cap;
                                addr       <= addr + ADDR_ONE;
                                ld_done    <= 1'b1;
                            end
                        end else if (i_rx_valid) begin
                            ld_done <= 1'b0;
                            state   <= RD_REQ;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed and randomized frames against a transaction-level model of the bridge:
// expected register accesses and MISO loads are derived from the frame bytes.
module tb_spi_reg_bridge;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic       i_spi_busy;
    logic       i_tx_ready;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic [6:0] o_reg_addr;
    logic [7:0] o_reg_wdata;
    logic       o_reg_wr;
    logic       o_reg_rd;
    logic [7:0] i_reg_rdata;
    logic       i_reg_rvalid;
    logic       o_err;

    spi_reg_bridge dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .i_spi_busy   (i_spi_busy),
        .i_tx_ready   (i_tx_ready),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .o_reg_addr   (o_reg_addr),
        .o_reg_wdata  (o_reg_wdata),
        .o_reg_wr     (o_reg_wr),
        .o_reg_rd     (o_reg_rd),
        .i_reg_rdata  (i_reg_rdata),
        .i_reg_rvalid (i_reg_rvalid),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int both_cnt = 0;

    logic [7:0] tx_q[$];
    logic [6:0] wr_a[$];
    logic [7:0] wr_d[$];
    int         wr_c[$];
    logic [6:0] rd_a[$];
    int         rd_c[$];
    int         err_c[$];
    int         rx_c[$];
    logic [7:0] fdata[8];

    bit rsp_on  = 1'b1;
    int rsp_lat = 2;

    always @(negedge i_clk) begin
        if (o_tx_valid) tx_q.push_back(o_tx_data);
        if (o_reg_wr) begin
            wr_a.push_back(o_reg_addr);
            wr_d.push_back(o_reg_wdata);
            wr_c.push_back(cyc);
        end
        if (o_reg_rd) begin
            rd_a.push_back(o_reg_addr);
            rd_c.push_back(cyc);
        end
        if (o_err) err_c.push_back(cyc);
        if (o_reg_wr && o_reg_rd) both_cnt = both_cnt + 1;
    end

    // Register file model: every address reads back as address + 0x40.
    initial begin : responder
        bit         pend;
        int         due;
        logic [6:0] raddr;
        pend = 1'b0;
        due = 0;
        raddr = '0;
        i_reg_rvalid = 1'b0;
        i_reg_rdata  = 8'h00;
        forever begin
            @(posedge i_clk);
            #1;
            i_reg_rvalid = 1'b0;
            if (pend && cyc == due) begin
                i_reg_rvalid = 1'b1;
                i_reg_rdata  = 8'({1'b0, raddr} + 8'h40);
                pend = 1'b0;
            end
            if (o_reg_rd && rsp_on) begin
                pend  = 1'b1;
                due   = cyc + rsp_lat;
                raddr = o_reg_addr;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_q();
        tx_q.delete();
        wr_a.delete();
        wr_d.delete();
        wr_c.delete();
        rd_a.delete();
        rd_c.delete();
        err_c.delete();
        rx_c.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit drop);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        if (drop) i_spi_busy = 1'b0;
        rx_c.push_back(cyc);
        step();
        i_rx_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] cmd, input int n, input int gap,
                             input bit drop_last, input bit to_mode, input int lat);
        logic [6:0] ea;
        logic [7:0] ed;
        rsp_on  = !to_mode;
        rsp_lat = lat;
        clear_q();
        repeat (4) step();
        chk("pre_frame_tx_cnt", 32'(tx_q.size()), 32'd0);
        i_spi_busy = 1'b1;
        step();
        step();
        send_byte(cmd, 1'b0);
        repeat (gap) step();
        for (int i = 0; i < n; i++) begin
            send_byte(fdata[i], (i == n - 1) && drop_last);
            if (i != n - 1) repeat (gap) step();
        end
        if (!drop_last) begin
            repeat (gap) step();
            i_spi_busy = 1'b0;
            step();
        end
        repeat (6) step();

        if (!cmd[7]) begin
            chk("wr_cnt", 32'(wr_a.size()), 32'(n));
            chk("rd_cnt_in_write", 32'(rd_a.size()), 32'd0);
            chk("tx_cnt_write", 32'(tx_q.size()), 32'(n + 1));
            for (int i = 0; i < n; i++) begin
                ea = cmd[6:0] + 7'(i);
                chk("wr_addr", (i < wr_a.size()) ? 32'(wr_a[i]) : 32'hFFFF_FFFF, 32'(ea));
                chk("wr_data", (i < wr_d.size()) ? 32'(wr_d[i]) : 32'hFFFF_FFFF, 32'(fdata[i]));
                chk("wr_latency", (i < wr_c.size()) ? 32'(wr_c[i] - rx_c[i + 1]) : 32'hFFFF_FFFF, 32'd1);
                chk("tx_echo", (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hFFFF_FFFF, 32'(fdata[i]));
            end
        end else begin
            chk("rd_cnt", 32'(rd_a.size()), 32'(n));
            chk("wr_cnt_in_read", 32'(wr_a.size()), 32'd0);
            chk("err_cnt", 32'(err_c.size()), to_mode ? 32'(n) : 32'd0);
            chk("tx_cnt_read", 32'(tx_q.size()), 32'(n + 1));
            for (int i = 0; i < n; i++) begin
                ea = cmd[6:0] + 7'(i);
                ed = to_mode ? 8'hEE : 8'({1'b0, ea} + 8'h40);
                chk("rd_addr", (i < rd_a.size()) ? 32'(rd_a[i]) : 32'hFFFF_FFFF, 32'(ea));
                chk("tx_rdata", (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hFFFF_FFFF, 32'(ed));
                if (to_mode)
                    chk("err_latency", (i < err_c.size() && i < rd_c.size()) ?
                        32'(err_c[i] - rd_c[i]) : 32'hFFFF_FFFF, 32'd16);
            end
        end
        chk("tx_sync_reload", (n < tx_q.size()) ? 32'(tx_q[n]) : 32'hFFFF_FFFF, 32'hA5);
    endtask

    initial begin : stim
        int k;
        i_rst_n    = 1'b0;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b0;
        i_spi_busy = 1'b0;
        i_tx_ready = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("rst_tx_valid", 32'(o_tx_valid), 32'd0);
        chk("rst_tx_data", 32'(o_tx_data), 32'd0);
        chk("rst_reg_addr", 32'(o_reg_addr), 32'd0);
        chk("rst_reg_wr", 32'(o_reg_wr), 32'd0);
        chk("rst_reg_rd", 32'(o_reg_rd), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        step();
        i_rst_n = 1'b1;
        clear_q();
        repeat (6) step();
        chk("sync_cnt", 32'(tx_q.size()), 32'd1);
        chk("sync_byte", (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'hFFFF_FFFF, 32'hA5);

        // Plain write frame, then a write whose last byte coincides with chip-select release.
        fdata[0] = 8'h11; fdata[1] = 8'h22; fdata[2] = 8'h33;
        run_frame(8'h10, 3, 2, 1'b0, 1'b0, 2);
        fdata[0] = 8'h5A; fdata[1] = 8'h6B;
        run_frame(8'h20, 2, 1, 1'b1, 1'b0, 2);

        // Reads: 2-clock latency, address wrap, and timeout.
        fdata[0] = 8'h00; fdata[1] = 8'hFF; fdata[2] = 8'h3C;
        run_frame(8'h85, 3, 30, 1'b1, 1'b0, 2);
        run_frame(8'hFF, 3, 30, 1'b1, 1'b0, 1);
        run_frame(8'h8A, 1, 30, 1'b1, 1'b1, 2);

        // Frame abandoned during a slow read; the late rvalid must be ignored.
        clear_q();
        rsp_on  = 1'b1;
        rsp_lat = 10;
        i_spi_busy = 1'b1;
        step();
        step();
        send_byte(8'h83, 1'b0);
        k = 0;
        while (rd_a.size() == 0 && k < 50) begin
            step();
            k++;
        end
        chk("abort_rd_seen", 32'(rd_a.size()), 32'd1);
        repeat (3) step();
        i_spi_busy = 1'b0;
        repeat (15) step();
        chk("abort_rd_addr", (rd_a.size() > 0) ? 32'(rd_a[0]) : 32'hFFFF_FFFF, 32'h03);
        chk("abort_tx_cnt", 32'(tx_q.size()), 32'd1);
        chk("abort_tx_sync", (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'hFFFF_FFFF, 32'hA5);
        chk("abort_err_cnt", 32'(err_c.size()), 32'd0);
        chk("abort_rd_cnt", 32'(rd_a.size()), 32'd1);
        fdata[0] = 8'h01; fdata[1] = 8'h02;
        run_frame(8'h90, 2, 30, 1'b1, 1'b0, 2);

        // Reset asserted mid-frame while a write strobe is high.
        clear_q();
        i_spi_busy = 1'b1;
        step();
        step();
        send_byte(8'h10, 1'b0);
        step();
        send_byte(8'h77, 1'b0);
        chk("pre_rst_wr_strobe", 32'(o_reg_wr), 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_wr", 32'(o_reg_wr), 32'd0);
        chk("async_rst_tx_valid", 32'(o_tx_valid), 32'd0);
        @(negedge i_clk);
        chk("mid_rst_wdata", 32'(o_reg_wdata), 32'd0);
        chk("mid_rst_addr", 32'(o_reg_addr), 32'd0);
        chk("mid_rst_tx_data", 32'(o_tx_data), 32'd0);
        step();
        step();
        i_rst_n = 1'b1;
        clear_q();
        repeat (3) step();
        send_byte(8'h12, 1'b0);
        step();
        send_byte(8'h34, 1'b0);
        repeat (4) step();
        chk("post_rst_no_wr", 32'(wr_a.size()), 32'd0);
        chk("post_rst_no_rd", 32'(rd_a.size()), 32'd0);
        chk("post_rst_sync_cnt", 32'(tx_q.size()), 32'd1);
        i_spi_busy = 1'b0;
        repeat (4) step();
        chk("post_rst_tx_cnt", 32'(tx_q.size()), 32'd1);
        fdata[0] = 8'hC3;
        run_frame(8'h40, 1, 2, 1'b0, 1'b0, 2);

        // Randomized frames.
        for (int f = 0; f < 12; f++) begin
            logic [7:0] c;
            int         n;
            bit         rd;
            bit         to;
            bit         dl;
            rd = 1'($urandom_range(0, 1));
            c  = {rd, 7'($urandom_range(0, 127))};
            n  = $urandom_range(1, 4);
            to = rd && ($urandom_range(0, 3) == 0);
            dl = rd ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) fdata[i] = 8'($urandom);
            run_frame(c, n, rd ? 30 : $urandom_range(0, 3), dl, to, $urandom_range(1, 4));
        end

        chk("wr_rd_overlap", 32'(both_cnt), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_reg_bridge.md
SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 7, meaning the register address width.
REQ-002 The block SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the first MISO byte of every frame.
REQ-003 The block SHALL have parameter ERR_BYTE, default 8'hEE, meaning the byte returned on a read timeout.
REQ-004 The block SHALL have parameter RD_TIMEOUT, default 16, meaning the maximum number of clocks to wait for i_reg_rvalid.
REQ-005 The block SHALL have a single clock, i_clk (input, 1), on which all state updates on the rising edge.
REQ-006 The block SHALL have reset i_rst_n (input, 1), asynchronous and active-low.
REQ-007 i_rx_data (input, 8) SHALL carry the byte received from the SPI slave.
REQ-008 i_rx_valid (input, 1) SHALL be a 1-clock pulse marking i_rx_data as valid.
REQ-009 i_spi_busy (input, 1) SHALL be high while SPI chip-select is asserted.
REQ-010 i_tx_ready (input, 1) SHALL indicate that the SPI slave accepts a transmit byte.
REQ-011 o_tx_data (output, 8) SHALL carry the next MISO byte.
REQ-012 o_tx_valid (output, 1) SHALL be a 1-clock load strobe for o_tx_data.
REQ-013 o_reg_addr (output, ADDR_W) SHALL carry the register address.
REQ-014 o_reg_wdata (output, 8) SHALL carry the register write data.
REQ-015 o_reg_wr (output, 1) SHALL be a 1-clock write strobe.
REQ-016 o_reg_rd (output, 1) SHALL be a 1-clock read strobe.
REQ-017 i_reg_rdata (input, 8) SHALL carry read data, valid when i_reg_rvalid is high.
REQ-018 i_reg_rvalid (input, 1) SHALL be a 1-clock pulse marking i_reg_rdata as valid, arriving 1 or more clocks after o_reg_rd.
REQ-019 o_err (output, 1) SHALL be a 1-clock pulse on read timeout.

Function
REQ-020 Frame protocol SHALL be: byte 0 = command, with bit7 = 1 for read and 0 for write, and bits[ADDR_W-1:0] = start address; bytes 1..N = data.
REQ-021 The FSM SHALL have states IDLE, CMD, WRITE, RD_REQ, RD_WAIT, RD_LOAD.
REQ-022 In IDLE with i_tx_ready=1 and no SYNC_BYTE loaded since the last frame, the block SHALL drive o_tx_data=SYNC_BYTE with o_tx_valid=1 for one clock; at most one such load SHALL occur per frame.
REQ-023 On the rising edge of i_spi_busy, IDLE SHALL go to CMD.
REQ-024 In CMD, i_rx_valid SHALL latch the address; bit7=0 SHALL go to WRITE, and bit7=1 SHALL go to RD_REQ.
REQ-025 In WRITE, each i_rx_valid SHALL assert o_reg_wr on the next clock, with o_reg_wdata=i_rx_data and o_reg_addr=current address.
REQ-026 In WRITE, the address SHALL increment by 1 after each write strobe.
REQ-027 In WRITE, the block SHALL load the written byte (echo) into o_tx_data with o_tx_valid=1 when i_tx_ready=1.
REQ-028 RD_REQ SHALL assert o_reg_rd for exactly one clock at the current address, then go to RD_WAIT and clear the timeout counter.
REQ-029 In RD_WAIT, i_reg_rvalid SHALL capture i_reg_rdata and go to RD_LOAD.
REQ-030 In RD_WAIT, if RD_TIMEOUT clocks elapse without i_reg_rvalid, the block SHALL capture ERR_BYTE, pulse o_err, and go to RD_LOAD.
REQ-031 RD_LOAD SHALL wait for i_tx_ready, then pulse o_tx_valid with the captured byte, increment the address, and wait for the next i_rx_valid (master dummy byte, discarded).
REQ-032 After that next i_rx_valid, the FSM SHALL return to RD_REQ.
REQ-033 The first read data therefore SHALL appear on MISO in byte 1, and successive addresses SHALL follow in bytes 2..N.
REQ-034 Address increment SHALL wrap modulo 2^ADDR_W (7F -> 00 at the default width).
REQ-035 When i_spi_busy falls in any state, the FSM SHALL go to IDLE on the next clock; pending reads SHALL be abandoned, and a later i_reg_rvalid SHALL be ignored.
REQ-036 If i_rx_valid and the falling edge of i_spi_busy occur in the same clock in WRITE, the write SHALL still be issued, followed by IDLE.
REQ-037 i_rx_valid received while in IDLE SHALL be ignored.
REQ-038 o_reg_wr and o_reg_rd SHALL never be high in the same clock.

Reset
REQ-039 While i_rst_n=0, all outputs SHALL be 0, the FSM SHALL be in IDLE, and the address, timeout counter and captured byte SHALL be 0.
REQ-040 Reset assertion mid-frame SHALL immediately clear all strobes; after release, the FSM SHALL remain in IDLE until the next rising edge of i_spi_busy.

Verification
REQ-041 Idle, tx_ready=1 -> exactly one o_tx_valid with o_tx_data=A5 before the frame; the first MISO byte reads A5.
REQ-042 Frame 0x10,0x11,0x22,0x33 -> o_reg_wr at addr 10/11/12 with data 11/22/33, each 1 clock after rx_valid; no o_reg_rd.
REQ-043 Frame 0x85,xx,xx,xx with a register model of 2-clock latency returning addr+0x40 -> o_reg_rd at 05,06,07; MISO = A5,45,46,47.
REQ-044 Read at 0x7F spanning 3 bytes -> read addresses 7F,00,01 (wrap).
REQ-045 Read with i_reg_rvalid never asserted -> o_err pulse 16 clocks after o_reg_rd; the MISO data byte = EE.
REQ-046 i_spi_busy dropped during RD_WAIT, then a late rvalid -> FSM in IDLE, no o_tx_valid except the SYNC_BYTE reload; the next frame behaves normally.
